// File: rtl/tx_byte_buffer.sv
// Byte FIFO feeding the UART TX data synchroniser, one byte per Busy rise/fall handshake.
// Optional drop counter output DROP_CNT is enabled by defining TX_BUF_DROP_CNT_EN.
module tx_byte_buffer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    input  logic                  Busy,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic [DATA_WIDTH-1:0] TX_P_Data,
    output logic                  TX_D_VLD,
    output logic                  TX_ERR
`ifdef TX_BUF_DROP_CNT_EN
    ,
    output logic [7:0]            DROP_CNT
`endif
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] w_tx_data_nxt;
    logic                  r_tx_vld;
    logic                  w_tx_vld_nxt;
    logic                  r_tx_err;
    logic                  w_tx_err_nxt;

    logic                  w_pop;
    logic                  w_push;

    assign EMPTY     = (r_count == '0);
    assign FULL      = (r_count == (ADDR_WIDTH + 1)'(DEPTH));
    assign COUNT     = r_count;
    assign TX_P_Data = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign TX_ERR    = r_tx_err;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
    assign w_push = WR_EN && (!FULL || w_pop);

    // Next-state and registered-output decode for the TX handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_tx_data_nxt = r_tx_data;
        w_tx_vld_nxt  = r_tx_vld;
        w_tx_err_nxt  = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!EMPTY && !Busy) begin
                    w_pop         = 1'b1;
                    w_tx_data_nxt = r_mem[r_rd_ptr];
                    w_tx_vld_nxt  = 1'b1;
                    w_timer_nxt   = '0;
                    w_state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (Busy) begin
                    w_tx_vld_nxt = 1'b0;
                    w_state_nxt  = ST_DRAIN;
                end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    // No acknowledge from the UART: the byte is abandoned.
                    w_tx_vld_nxt = 1'b0;
                    w_tx_err_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!Busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_tx_vld_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // FSM state and handshake output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_tx_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_tx_err  <= w_tx_err_nxt;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array is intentionally left out of reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

`ifdef TX_BUF_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop   = WR_EN && FULL && !w_pop;
    assign DROP_CNT = r_drop_cnt;

    // Saturating count of writes lost to a full FIFO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_byte_buffer.sv
// Directed bench for tx_byte_buffer: vector table plus hand sequences for timeout, reset and wrap.
module tb_tx_byte_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_err;
`ifdef TX_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tx_byte_buffer dut (
        .CLK       (clk),
        .RST       (rst),
        .WR_DATA   (wr_data),
        .WR_EN     (wr_en),
        .Busy      (busy),
        .FULL      (full),
        .EMPTY     (empty),
        .COUNT     (count),
        .TX_P_Data (tx_data),
        .TX_D_VLD  (tx_vld),
        .TX_ERR    (tx_err)
`ifdef TX_BUF_DROP_CNT_EN
        ,
        .DROP_CNT  (drop_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] data;
        logic       busy;
        logic       vld;
        logic [7:0] tdata;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
        logic [7:0] drop;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic r, input logic w, input logic [7:0] d,
                        input logic b, input logic v, input logic [7:0] td, input logic [3:0] c,
                        input logic f, input logic e, input logic er, input logic [7:0] dr);
        vecs[i].rst   = r;
        vecs[i].wr    = w;
        vecs[i].data  = d;
        vecs[i].busy  = b;
        vecs[i].vld   = v;
        vecs[i].tdata = td;
        vecs[i].cnt   = c;
        vecs[i].full  = f;
        vecs[i].empty = e;
        vecs[i].err   = er;
        vecs[i].drop  = dr;
    endtask

    // Ack model: wait for a byte, check it, then pulse Busy for two cycles.
    task automatic get_byte(input logic [7:0] exp);
        int waited = 0;
        while (!tx_vld && waited < 200) begin
            tick();
            waited++;
        end
        chk("issue_wait", 32'(tx_vld), 32'd1);
        if (tx_vld) begin
            chk("byte_order", 32'(tx_data), 32'(exp));
            busy = 1'b1;
            tick();
            chk("vld_drop_on_busy", 32'(tx_vld), 32'd0);
            tick();
            busy = 1'b0;
            tick();
        end
    endtask

    logic [7:0] m_q [$];
    int         m_st;
    logic       m_vld;
    logic       m_pop;
    logic       m_acc;
    logic [7:0] m_data;

    initial begin
        logic [7:0] order [8];
        int         n;
        int         guard;
        logic       seen;
        int         wcnt;
        int         rx;
        int         hold;
        int         cyc;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        busy    = 1'b0;

        // Reset, single byte handshake, then fill to FULL with Busy held, drop, pop+write.
        setv(0,  1, 0, 8'h00, 0,  0, 8'h00, 4'd0, 0, 1, 0, 8'd0);
        setv(1,  0, 1, 8'hA5, 0,  0, 8'h00, 4'd1, 0, 0, 0, 8'd0);
        setv(2,  0, 0, 8'h00, 0,  1, 8'hA5, 4'd0, 0, 1, 0, 8'd0);
        setv(3,  0, 0, 8'h00, 1,  0, 8'hA5, 4'd0, 0, 1, 0, 8'd0);
        setv(4,  0, 0, 8'h00, 1,  0, 8'hA5, 4'd0, 0, 1, 0, 8'd0);
        setv(5,  0, 0, 8'h00, 0,  0, 8'hA5, 4'd0, 0, 1, 0, 8'd0);
        setv(6,  0, 0, 8'h00, 0,  0, 8'hA5, 4'd0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            setv(7 + i, 0, 1, 8'(i + 1), 1, 0, 8'hA5, 4'(i + 1), (i == 7), 0, 0, 8'd0);
        end
        setv(15, 0, 1, 8'h09, 1,  0, 8'hA5, 4'd8, 1, 0, 0, 8'd1);
        setv(16, 0, 1, 8'h10, 0,  1, 8'h01, 4'd8, 1, 0, 0, 8'd1);

        for (int i = 0; i < NVEC; i++) begin
            rst     = vecs[i].rst;
            wr_en   = vecs[i].wr;
            wr_data = vecs[i].data;
            busy    = vecs[i].busy;
            tick();
            chk($sformatf("v%0d_vld", i),   32'(tx_vld),  32'(vecs[i].vld));
            chk($sformatf("v%0d_data", i),  32'(tx_data), 32'(vecs[i].tdata));
            chk($sformatf("v%0d_count", i), 32'(count),   32'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(full),    32'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), 32'(empty),   32'(vecs[i].empty));
            chk($sformatf("v%0d_err", i),   32'(tx_err),  32'(vecs[i].err));
`ifdef TX_BUF_DROP_CNT_EN
            chk($sformatf("v%0d_drop", i),  32'(drop_cnt), 32'(vecs[i].drop));
`endif
        end

        // Drain: 01..08 then 10; the dropped 09 must never appear.
        wr_en = 1'b0;
        order = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10};
        get_byte(8'h01);
        for (int i = 0; i < 8; i++) begin
            get_byte(order[i]);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_vld) seen = 1'b1;
        end
        chk("no_stale_09", 32'(seen), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Ack timeout: 55 is abandoned after 64 cycles, then 66 goes out.
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_data = 8'h66;
        tick();
        wr_en = 1'b0;
        busy  = 1'b0;
        tick();
        chk("to_first_vld", 32'(tx_vld), 32'd1);
        chk("to_first_data", 32'(tx_data), 32'h55);
        chk("to_first_count", 32'(count), 32'd1);
        n     = 1;
        guard = 0;
        while (tx_vld && guard < 100) begin
            tick();
            guard++;
            if (tx_vld) n++;
        end
        chk("to_vld_cycles", 32'(n), 32'd64);
        chk("to_err_pulse", 32'(tx_err), 32'd1);
        tick();
        chk("to_err_clear", 32'(tx_err), 32'd0);
        chk("to_next_vld", 32'(tx_vld), 32'd1);
        chk("to_next_data", 32'(tx_data), 32'h66);
        chk("to_next_count", 32'(count), 32'd0);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();

        // Reset while in SEND with three bytes still queued.
        busy  = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h71 + i);
            tick();
        end
        wr_en = 1'b0;
        busy  = 1'b0;
        tick();
        chk("rs_send_vld", 32'(tx_vld), 32'd1);
        chk("rs_send_data", 32'(tx_data), 32'h71);
        chk("rs_send_count", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_vld", 32'(tx_vld), 32'd0);
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_empty", 32'(empty), 32'd1);
        chk("rs_full", 32'(full), 32'd0);
        chk("rs_data", 32'(tx_data), 32'd0);
`ifdef TX_BUF_DROP_CNT_EN
        chk("rs_drop", 32'(drop_cnt), 32'd0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_vld) seen = 1'b1;
        end
        chk("rs_no_stale", 32'(seen), 32'd0);

        // 20 bytes with a Busy responder; queue model tracks COUNT every cycle.
        m_st  = 0;
        m_vld = 1'b0;
        wcnt  = 0;
        rx    = 0;
        hold  = 0;
        cyc   = 0;
        while ((rx < 20 || m_st != 0) && cyc < 600) begin
            wr_en   = (wcnt < 20) && (cyc % 4 != 3) && (m_q.size() < 8);
            wr_data = 8'(8'h80 + wcnt);
            m_pop   = (m_st == 0) && (m_q.size() != 0) && !busy;
            m_acc   = wr_en && ((m_q.size() < 8) || m_pop);
            if (m_pop) begin
                m_data = m_q.pop_front();
                m_vld  = 1'b1;
                m_st   = 1;
            end else if (m_st == 1) begin
                if (busy) begin
                    m_vld = 1'b0;
                    m_st  = 2;
                end
            end else if (m_st == 2) begin
                if (!busy) m_st = 0;
            end
            if (m_acc) begin
                m_q.push_back(wr_data);
                wcnt++;
            end
            tick();
            chk("wr_count", 32'(count), 32'(m_q.size()));
            chk("wr_vld", 32'(tx_vld), 32'(m_vld));
            if (m_pop) begin
                chk("wr_order", 32'(tx_data), 32'(8'(8'h80 + rx)));
                chk("wr_model_data", 32'(tx_data), 32'(m_data));
                rx++;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) busy = 1'b0;
            end else if (tx_vld && !busy) begin
                busy = 1'b1;
                hold = 3;
            end
            cyc++;
        end
        wr_en = 1'b0;
        busy  = 1'b0;
        chk("wr_all_received", 32'(rx), 32'd20);
        chk("wr_final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
